// File: rtl/sid_waveform_mixer.sv
// sid_waveform_mixer: per-voice waveform combiner between the waveform
// generator and the voice DAC. ANDs the selected noise/pulse/saw/triangle
// words, models the decaying floating DAC input when nothing is selected,
// and feeds combined-waveform bits back to the noise LFSR.

package sid;

  typedef enum logic {
    MOS6581 = 1'b0,
    MOS8580 = 1'b1
  } model_e;

  // One-hot cycle phase strobes; PHI2 marks the sample cycle.
  localparam int unsigned PHI1 = 0;
  localparam int unsigned PHI2 = 1;
  typedef logic [1:0] phase_t;

  typedef struct packed {
    logic [3:0]  selector;  // {N,P,S,T}
    logic [7:0]  noise;
    logic        pulse;
    logic [11:0] saw_tri;
  } waveform_i_t;

endpackage

module sid_waveform_mixer #(
  parameter logic [23:0] FLOAT_TTL_6581 = 24'h01_4000,
  parameter logic [23:0] FLOAT_TTL_8580 = 24'h4C_4000
) (
  input  logic              clk,
  input  logic              res,
  input  sid::model_e       model,
  input  sid::phase_t       phase,
  input  sid::waveform_i_t  wave_i,
  output logic [11:0]       wave_o,
  output logic [7:0]        noise_wb,
  output logic              noise_wb_en
);

  typedef enum logic {
    ST_DRIVEN = 1'b0,
    ST_FLOAT  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] age_q, age_d;
  logic [11:0] wave_q, wave_d;
  logic [7:0]  nwb_q, nwb_d;
  logic        nwb_en_q, nwb_en_d;

  logic        strobe_s;
  logic        sel_any_s;
  logic        wb_s;
  logic [11:0] tri_s, saw_s, pul_s, noi_s, mix_s;
  logic [23:0] ttl_s;
  logic [24:0] age_inc_s;
  logic        expired_s;

  // Decode the sample strobe, build component words and the AND mix.
  always_comb begin
    strobe_s  = phase[sid::PHI2];
    sel_any_s = (wave_i.selector != 4'b0000);
    wb_s      = wave_i.selector[3] && (wave_i.selector[2:0] != 3'b000);
    tri_s     = {wave_i.saw_tri[10:0], 1'b0};
    saw_s     = wave_i.saw_tri;
    pul_s     = {12{wave_i.pulse}};
    noi_s     = {wave_i.noise, 4'b0000};
    mix_s     = (wave_i.selector[0] ? tri_s : 12'hFFF)
              & (wave_i.selector[1] ? saw_s : 12'hFFF)
              & (wave_i.selector[2] ? pul_s : 12'hFFF)
              & (wave_i.selector[3] ? noi_s : 12'hFFF);
  end

  // Pick the floating-value lifetime for the current chip model and test
  // whether one more strobe reaches or passes it (a model switch can leave
  // the running age already beyond the new limit).
  always_comb begin
    case (model)
      sid::MOS6581: ttl_s = FLOAT_TTL_6581;
      sid::MOS8580: ttl_s = FLOAT_TTL_8580;
      default:      ttl_s = FLOAT_TTL_6581;
    endcase
    age_inc_s = {1'b0, age_q} + 25'd1;
    expired_s = (age_inc_s >= {1'b0, ttl_s});
  end

  // State register: all flops, synchronous reset has priority over strobes.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= ST_DRIVEN;
      age_q    <= 24'd0;
      wave_q   <= 12'd0;
      nwb_q    <= 8'd0;
      nwb_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      age_q    <= age_d;
      wave_q   <= wave_d;
      nwb_q    <= nwb_d;
      nwb_en_q <= nwb_en_d;
    end
  end

  // Next state: any selected waveform drives the DAC, none lets it float.
  always_comb begin
    state_d = state_q;
    if (strobe_s) begin
      if (sel_any_s) begin
        state_d = ST_DRIVEN;
      end else begin
        state_d = ST_FLOAT;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Datapath: DAC value, floating age and LFSR writeback for this strobe.
  always_comb begin
    wave_d   = wave_q;
    age_d    = age_q;
    nwb_d    = nwb_q;
    nwb_en_d = 1'b0;
    if (strobe_s) begin
      if (sel_any_s) begin
        wave_d = mix_s;
        age_d  = 24'd0;
        if (wb_s) begin
          nwb_d    = mix_s[11:4];
          nwb_en_d = 1'b1;
        end else begin
          nwb_d    = nwb_q;
          nwb_en_d = 1'b0;
        end
      end else begin
        case (state_q)
          ST_DRIVEN: begin
            // First floating strobe always holds the last driven value.
            wave_d = wave_q;
            age_d  = 24'd1;
          end
          ST_FLOAT: begin
            if (expired_s) begin
              wave_d = 12'd0;
              age_d  = ttl_s;
            end else begin
              wave_d = wave_q;
              age_d  = age_inc_s[23:0];
            end
          end
          default: begin
            wave_d = wave_q;
            age_d  = 24'd0;
          end
        endcase
      end
    end else begin
      wave_d = wave_q;
      age_d  = age_q;
    end
  end

  assign wave_o      = wave_q;
  assign noise_wb    = nwb_q;
  assign noise_wb_en = nwb_en_q;

endmodule
